// File: rtl/memory_port_arbiter_if.sv
// ============================================================================
// memory_port_arbiter_if : two-master request bus plus shared memory port
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface memory_port_arbiter_if;
    logic        req0,     req1;
    logic        wen0,     wen1;
    logic [31:0] addr0,    addr1;
    logic [31:0] wdata0,   wdata1;
    logic [3:0]  byte_en0, byte_en1;
    logic [31:0] rdata0,   rdata1;
    logic        wait0,    wait1;
    logic        err0,     err1;

    logic        mem_en;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata;
    logic        mem_wait;

    // Arbiter side
    modport slave (
        input  req0, req1, wen0, wen1, addr0, addr1, wdata0, wdata1,
               byte_en0, byte_en1, mem_rdata, mem_wait,
        output rdata0, rdata1, wait0, wait1, err0, err1,
               mem_en, mem_wen, mem_addr, mem_wdata, mem_byte_en
    );

    // Environment side: both bus masters and the memory
    modport master (
        output req0, req1, wen0, wen1, addr0, addr1, wdata0, wdata1,
               byte_en0, byte_en1, mem_rdata, mem_wait,
        input  rdata0, rdata1, wait0, wait1, err0, err1,
               mem_en, mem_wen, mem_addr, mem_wdata, mem_byte_en
    );
endinterface

`default_nettype wire

// File: rtl/memory_port_arbiter.sv
// ============================================================================
// memory_port_arbiter : two-port round-robin arbiter with access watchdog
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   nRST,
    memory_port_arbiter_if.slave   bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      ABORT_DATA = 32'hBAD1BAD1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q,   state_d;
    logic              gnt_q,     gnt_d;
    logic              last_q,    last_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              wen_q,     wen_d;
    logic [31:0]       addr_q,    addr_d;
    logic [31:0]       wdata_q,   wdata_d;
    logic [3:0]        byte_en_q, byte_en_d;

    logic              done;
    logic              abort;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            byte_en_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            byte_en_q <= byte_en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        byte_en_d = byte_en_q;
        done      = 1'b0;
        abort     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // Contention goes to whichever port was not served last
                    gnt_d     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    wen_d     = gnt_d ? bus.wen1     : bus.wen0;
                    addr_d    = gnt_d ? bus.addr1    : bus.addr0;
                    wdata_d   = gnt_d ? bus.wdata1   : bus.wdata0;
                    byte_en_d = gnt_d ? bus.byte_en1 : bus.byte_en0;
                    cnt_d     = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                abort = (TIMEOUT_CYCLES != 0) && bus.mem_wait && (cnt_q == CNT_LAST);
                done  = !bus.mem_wait || abort;
                if (done) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [31:0] done_rdata;
    assign done_rdata = abort ? ABORT_DATA : bus.mem_rdata;

    assign bus.wait0  = !(done && !gnt_q);
    assign bus.wait1  = !(done &&  gnt_q);
    assign bus.rdata0 = (done && !gnt_q) ? done_rdata : '0;
    assign bus.rdata1 = (done &&  gnt_q) ? done_rdata : '0;
    assign bus.err0   = abort && !gnt_q;
    assign bus.err1   = abort &&  gnt_q;

    assign bus.mem_en      = (state_q == BUSY);
    assign bus.mem_wen     = wen_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_byte_en = byte_en_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
// ============================================================================
// tb_memory_port_arbiter : directed self-checking bench for the arbiter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_port_arbiter;

    logic clk;
    logic nRST;

    memory_port_arbiter_if bus();
    memory_port_arbiter_if bus_nt();

    memory_port_arbiter #(.TIMEOUT_CYCLES(4)) u_dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    memory_port_arbiter #(.TIMEOUT_CYCLES(0)) u_dut_nt (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus_nt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        req0;
        logic        req1;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic        mem_wait;
        logic [31:0] mem_rdata;
        logic        e_mem_en;
        logic [31:0] e_mem_addr;
        logic        e_wait0;
        logic        e_wait1;
        logic [31:0] e_rdata0;
        logic [31:0] e_rdata1;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mem_en"},      bus.mem_en,      0);
        chk({tag, "_mem_wen"},     bus.mem_wen,     0);
        chk({tag, "_mem_addr"},    bus.mem_addr,    0);
        chk({tag, "_mem_wdata"},   bus.mem_wdata,   0);
        chk({tag, "_mem_byte_en"}, bus.mem_byte_en, 0);
        chk({tag, "_wait0"},       bus.wait0,       1);
        chk({tag, "_wait1"},       bus.wait1,       1);
        chk({tag, "_rdata0"},      bus.rdata0,      0);
        chk({tag, "_rdata1"},      bus.rdata1,      0);
        chk({tag, "_err0"},        bus.err0,        0);
        chk({tag, "_err1"},        bus.err1,        0);
    endtask

    initial begin
        int nt_done;
        int low0;

        nRST = 1'b0;
        bus.req0 = 0; bus.req1 = 0; bus.wen0 = 0; bus.wen1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        bus.byte_en0 = 0; bus.byte_en1 = 0; bus.mem_rdata = 0; bus.mem_wait = 1;
        bus_nt.req0 = 0; bus_nt.req1 = 0; bus_nt.wen0 = 0; bus_nt.wen1 = 0;
        bus_nt.addr0 = 0; bus_nt.addr1 = 0; bus_nt.wdata0 = 0; bus_nt.wdata1 = 0;
        bus_nt.byte_en0 = 0; bus_nt.byte_en1 = 0; bus_nt.mem_rdata = 0; bus_nt.mem_wait = 1;

        //           req0 req1 addr0         addr1         wait  mem_rdata      en  mem_addr      w0 w1 rdata0         rdata1
        vecs[0] = '{1'b1, 1'b0, 32'h00001000, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h00001000, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 32'h00001000, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h0};
        vecs[3] = '{1'b1, 1'b1, 32'h00000100, 32'h00000200, 1'b0, 32'h11111111, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h0};
        vecs[4] = '{1'b1, 1'b1, 32'h00000100, 32'h00000200, 1'b0, 32'h22222222, 1'b1, 32'h00000200, 1'b1, 1'b0, 32'h0,        32'h22222222};
        vecs[5] = '{1'b1, 1'b1, 32'h00000100, 32'h00000200, 1'b0, 32'h33333333, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h0};
        vecs[6] = '{1'b1, 1'b1, 32'h00000100, 32'h00000200, 1'b0, 32'h44444444, 1'b1, 32'h00000100, 1'b0, 1'b1, 32'h44444444, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 32'h00000100, 32'h00000200, 1'b0, 32'h55555555, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h0};
        vecs[8] = '{1'b1, 1'b1, 32'h00000100, 32'h00000200, 1'b0, 32'h66666666, 1'b1, 32'h00000200, 1'b1, 1'b0, 32'h0,        32'h66666666};
        vecs[9] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h0};

        repeat (2) @(negedge clk);
        chk_reset("reset");
        next();
        nRST = 1'b1;

        // Single read on port 0, then continuous contention
        for (int i = 0; i < 10; i++) begin
            bus.req0      = vecs[i].req0;
            bus.req1      = vecs[i].req1;
            bus.addr0     = vecs[i].addr0;
            bus.addr1     = vecs[i].addr1;
            bus.mem_wait  = vecs[i].mem_wait;
            bus.mem_rdata = vecs[i].mem_rdata;
            @(negedge clk);
            chk($sformatf("v%0d_mem_en", i), bus.mem_en, vecs[i].e_mem_en);
            if (vecs[i].e_mem_en) begin
                chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].e_mem_addr);
                chk($sformatf("v%0d_mem_wen", i),  bus.mem_wen,  0);
            end
            chk($sformatf("v%0d_wait0", i),  bus.wait0,  vecs[i].e_wait0);
            chk($sformatf("v%0d_wait1", i),  bus.wait1,  vecs[i].e_wait1);
            chk($sformatf("v%0d_rdata0", i), bus.rdata0, vecs[i].e_rdata0);
            chk($sformatf("v%0d_rdata1", i), bus.rdata1, vecs[i].e_rdata1);
            chk($sformatf("v%0d_err0", i),   bus.err0,   0);
            chk($sformatf("v%0d_err1", i),   bus.err1,   0);
            next();
        end

        // Port 1 write stalled three cycles, inputs scrambled after grant
        bus.req1 = 1; bus.wen1 = 1; bus.addr1 = 32'h00002004;
        bus.wdata1 = 32'h12345678; bus.byte_en1 = 4'b0011;
        bus.mem_wait = 1; bus.mem_rdata = 32'h5555AAAA;
        @(negedge clk);
        chk("ws_idle_mem_en", bus.mem_en, 0);
        next();
        bus.wen1 = 0; bus.addr1 = 32'hFFFF0000; bus.wdata1 = 32'h0; bus.byte_en1 = 4'b1100;
        for (int c = 1; c <= 4; c++) begin
            bus.mem_wait = (c < 4);
            @(negedge clk);
            chk($sformatf("ws%0d_mem_en", c),      bus.mem_en,      1);
            chk($sformatf("ws%0d_mem_wen", c),     bus.mem_wen,     1);
            chk($sformatf("ws%0d_mem_addr", c),    bus.mem_addr,    32'h00002004);
            chk($sformatf("ws%0d_mem_wdata", c),   bus.mem_wdata,   32'h12345678);
            chk($sformatf("ws%0d_mem_byte_en", c), bus.mem_byte_en, 4'b0011);
            chk($sformatf("ws%0d_wait1", c),       bus.wait1,       (c < 4) ? 1 : 0);
            chk($sformatf("ws%0d_err1", c),        bus.err1,        0);
            chk($sformatf("ws%0d_wait0", c),       bus.wait0,       1);
            if (c == 4) chk("ws4_rdata1", bus.rdata1, 32'h5555AAAA);
            next();
        end
        bus.req1 = 0; bus.mem_wait = 1;
        @(negedge clk);
        chk("ws_after_mem_en", bus.mem_en, 0);
        chk("ws_after_wait1",  bus.wait1,  1);
        next();

        // Watchdog abort in the 4th stalled BUSY cycle
        bus.req0 = 1; bus.addr0 = 32'h00003000; bus.mem_wait = 1; bus.mem_rdata = 32'h12121212;
        @(negedge clk);
        chk("to_idle_mem_en", bus.mem_en, 0);
        next();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) bus.req0 = 0;
            @(negedge clk);
            chk($sformatf("to%0d_mem_en", c), bus.mem_en, 1);
            chk($sformatf("to%0d_wait0", c),  bus.wait0,  (c < 4) ? 1 : 0);
            chk($sformatf("to%0d_err0", c),   bus.err0,   (c == 4) ? 1 : 0);
            chk($sformatf("to%0d_rdata0", c), bus.rdata0, (c == 4) ? 32'hBAD1BAD1 : 32'h0);
            chk($sformatf("to%0d_wait1", c),  bus.wait1,  1);
            next();
        end
        @(negedge clk);
        chk("to_after_mem_en", bus.mem_en, 0);
        chk("to_after_err0",   bus.err0,   0);
        next();

        // Watchdog disabled: a stall never aborts
        bus_nt.req0 = 1; bus_nt.addr0 = 32'h00004000; bus_nt.mem_wait = 1;
        nt_done = 0;
        repeat (1001) begin
            @(negedge clk);
            if (!bus_nt.wait0 || bus_nt.err0) nt_done++;
            next();
        end
        chk("nt_no_abort", nt_done, 0);
        bus_nt.mem_wait = 0; bus_nt.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("nt_mem_en",  bus_nt.mem_en, 1);
        chk("nt_wait0",   bus_nt.wait0,  0);
        chk("nt_err0",    bus_nt.err0,   0);
        chk("nt_rdata0",  bus_nt.rdata0, 32'hCAFEF00D);
        bus_nt.req0 = 0; bus_nt.mem_wait = 1;
        next();

        // Reset during a stalled port-1 access
        bus.req0 = 1; bus.req1 = 1; bus.addr0 = 32'h00000100; bus.addr1 = 32'h00000200;
        bus.wen1 = 1; bus.wdata1 = 32'hA5A5A5A5; bus.byte_en1 = 4'hF; bus.mem_wait = 1;
        @(negedge clk);
        chk("rs_idle_mem_en", bus.mem_en, 0);
        next();
        @(negedge clk);
        chk("rs_busy_mem_en",   bus.mem_en,   1);
        chk("rs_busy_mem_addr", bus.mem_addr, 32'h00000200);
        #1;
        nRST = 1'b0;
        bus.mem_wait = 0;
        #1;
        chk_reset("rs_async");
        next();
        chk("rs_hold_wait1",  bus.wait1,  1);
        chk("rs_hold_mem_en", bus.mem_en, 0);
        nRST = 1'b1;
        bus.wen1 = 0;
        bus.mem_wait = 1;
        @(negedge clk);
        chk("rs_rel_mem_en", bus.mem_en, 0);
        next();
        bus.mem_wait = 0; bus.mem_rdata = 32'h77777777;
        @(negedge clk);
        chk("rs_first_addr",   bus.mem_addr, 32'h00000100);
        chk("rs_first_wait0",  bus.wait0,    0);
        chk("rs_first_rdata0", bus.rdata0,   32'h77777777);
        chk("rs_first_wait1",  bus.wait1,    1);
        bus.req0 = 0; bus.req1 = 0;
        next();

        // Request dropped the cycle after grant
        bus.req0 = 1; bus.addr0 = 32'h00006000; bus.mem_wait = 1;
        @(negedge clk);
        chk("dr_idle_mem_en", bus.mem_en, 0);
        next();
        bus.req0 = 0;
        @(negedge clk);
        chk("dr_busy_mem_en",   bus.mem_en,   1);
        chk("dr_busy_mem_addr", bus.mem_addr, 32'h00006000);
        chk("dr_busy_wait0",    bus.wait0,    1);
        next();
        bus.mem_wait = 0; bus.mem_rdata = 32'h89ABCDEF;
        @(negedge clk);
        chk("dr_done_wait0",  bus.wait0,  0);
        chk("dr_done_rdata0", bus.rdata0, 32'h89ABCDEF);
        next();
        low0 = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("dr_after%0d_mem_en", c), bus.mem_en, 0);
            if (!bus.wait0) low0++;
            next();
        end
        chk("dr_no_extra_done", low0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Two-port round-robin arbiter that shares the single SoC memory request port (the `sram_controller_if` side of the memory block controller covering ROM/RAM/SRAM) between two bus masters. Port 0 is the CPU data side; port 1 is the DMA/debug side. The block accepts one transaction at a time and captures its address, write data, write enable and byte enables into registers. It holds those values on the memory port until the memory deasserts wait, then hands the result back to the granted master. A per-transaction watchdog aborts accesses that never complete and returns an error.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: number of consecutive waiting cycles before an abort. A value of 0 disables the watchdog.

Ports:
- `clk`  in  1  clock
- `nRST`  in  1  reset, asynchronous, active-low
- `req0`, `req1`  in  1  request from port 0 / port 1; held high until done
- `wen0`, `wen1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  32  byte address
- `wdata0`, `wdata1`  in  32  write data
- `byte_en0`, `byte_en1`  in  4  byte enables
- `rdata0`, `rdata1`  out  32  read data; valid only in the done cycle
- `wait0`, `wait1`  out  1  1 = not done; 0 for exactly one cycle = done
- `err0`, `err1`  out  1  1-cycle pulse coincident with done when the transaction was aborted by the watchdog
- `mem_en`  out  1  memory access active (drives `sram_en`)
- `mem_wen`  out  1  captured write enable
- `mem_addr`  out  32  captured address
- `mem_wdata`  out  32  captured write data
- `mem_byte_en`  out  4  captured byte enables
- `mem_rdata`  in  32  memory read data
- `mem_wait`  in  1  memory busy; 0 = access completes this cycle

## Operation
States:
- IDLE
- BUSY

Registers:
- `gnt`: the granted port, 1 bit.
- `last`: the last granted port, 1 bit.
- Capture registers for `wen`, `addr`, `wdata` and `byte_en`.
- Watchdog counter, `$clog2(TIMEOUT_CYCLES+1)` bits, saturating.

IDLE:
- `mem_en` = 0.
- If only one request is high, grant that port.
- If both requests are high, grant the port that is not `last`.
- On a grant, load the capture registers from the granted port, set `gnt`, clear the counter, and go to BUSY.
- With no request, stay in IDLE.

BUSY:
- `mem_en` = 1. The `mem_*` outputs come from the capture registers.
- **Normal completion** (`mem_wait` = 0):
  - The granted port sees `wait` = 0 and `rdata` = `mem_rdata`.
  - `last` is set to `gnt`.
  - Next state is IDLE.
- **Still waiting** (`mem_wait` = 1): the counter increments.
- **Watchdog abort** (`TIMEOUT_CYCLES` != 0, `mem_wait` = 1 and counter == `TIMEOUT_CYCLES-1`):
  - The granted port sees `wait` = 0, `err` = 1 and `rdata` = 32'hBAD1BAD1.
  - `last` is set to `gnt`.
  - Next state is IDLE.

Output rules in all states:
- The port that is not granted always sees `wait` = 1, `rdata` = 0 and `err` = 0.
- `rdata` = 0 whenever a port is not in its done cycle.
- `wait` = 1 regardless of that port's `req`, except in the done cycle.

Boundary conditions:
- A request dropped while in BUSY is a protocol violation. The transaction still completes from the captured values, and the done pulse is still emitted.
- Changing `addr`/`wdata` while in BUSY has no effect.
- A requester that keeps `req` high after its done cycle is treated as a new request in the next IDLE cycle. Round-robin still applies, so it loses to a pending other port.

## Timing
Reset values while nRST = 0:
- State IDLE, `last` = 1 (port 0 wins first), `gnt` = 0, counter = 0.
- Capture registers 0, so `mem_en`/`mem_wen`/`mem_addr`/`mem_wdata`/`mem_byte_en` = 0.
- `wait0` = `wait1` = 1; `rdata0` = `rdata1` = 0; `err0` = `err1` = 0.

Reset asserted mid-transaction:
- Everything returns immediately and asynchronously to the reset values; no done pulse is emitted.
- After release, arbitration restarts with port 0 priority.

Latency:
- A request sampled high at edge k gives BUSY with `mem_en` = 1 in cycle k+1.
- If `mem_wait` = 0 in that cycle, done occurs in cycle k+1 (one cycle of latency).
- Every IDLE gap lasts one cycle, so the maximum issue rate is one access per 2 cycles.

Timing paths:
- `rdata`, `wait` and `err` are combinational from `mem_rdata`/`mem_wait` and the registered state.
- All `mem_*` outputs are registered.

Watchdog: with `TIMEOUT_CYCLES` = N, an access that has `mem_wait` = 1 continuously aborts in its Nth BUSY cycle.

## Test plan
- **Single read on port 0**: `req0` with `addr0` = 0x1000; memory returns `mem_wait` = 0 with `mem_rdata` = 0xDEADBEEF in the first BUSY cycle. Required: `mem_addr` = 0x1000, `mem_wen` = 0, `rdata0` = 0xDEADBEEF, `wait0` = 0 for exactly 1 cycle, `wait1` = 1 throughout.
- **Simultaneous requests**: `req0` and `req1` held high continuously. Required: grants alternate 0, 1, 0, 1 with a done every 2 cycles when `mem_wait` = 0.
- **Write with stall**: port 1 write, `addr1` = 0x2004, `wdata1` = 0x12345678, `byte_en1` = 4'b0011; `mem_wait` high 3 cycles. Required: captured values stay stable for 4 BUSY cycles even when the port-1 inputs change after the grant, `wait1` falls in the 4th BUSY cycle, and `err1` = 0.
- **Timeout**: `TIMEOUT_CYCLES` = 4 and `mem_wait` stuck at 1. Required: in the 4th BUSY cycle `wait0` = 0, `err0` = 1 and `rdata0` = 0xBAD1BAD1, followed by IDLE with `mem_en` = 0. Repeat with `TIMEOUT_CYCLES` = 0: no abort occurs within 1000 cycles.
- **Reset mid-BUSY**: assert nRST low during a stalled access. Required: all outputs reach their reset values within the same cycle, no done pulse is emitted, and after release the first simultaneous request grants port 0.
- **Request dropped in BUSY**: `req0` falls the cycle after grant. Required: the access still completes on `mem_wait` = 0 with a single `wait0` = 0 cycle, and no second access is issued.
